mac_pipe: RTL and testbench

MAC_PIPE -- requirements
Module: mac_pipe

---
 rtl/mac_if.sv | 30 +++
 rtl/mac_pipe.sv | 114 +++++++++++
 tb/tb_mac_pipe.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_if.sv
// Operand/result handshake bundle for the pipelined multiply-accumulate block.
// The upstream side (operand source and result sink) uses the master modport.
interface mac_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic              mode;
  logic              last;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [ACC_W-1:0]  c;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  result;
  logic              sat;
  logic              sat_sticky;

  modport master (
    output clear, in_valid, mode, last, a, b, c, out_ready,
    input  in_ready, out_valid, result, sat, sat_sticky
  );

  modport slave (
    input  clear, in_valid, mode, last, a, b, c, out_ready,
    output in_ready, out_valid, result, sat, sat_sticky
  );
endinterface

// File: rtl/mac_pipe.sv
// Two-stage signed multiply-add / multiply-accumulate pipeline with saturation.
// S1 holds the product and the operation controls, S2 holds the saturated
// result. Both stages move together whenever the output slot is free.
module mac_pipe #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic clk,
  input  logic rst_n,
  mac_if.slave bus
);
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = ACC_W + 1;

  // Stage 1 state
  logic              s1_valid_reg;
  logic [PROD_W-1:0] s1_prod_reg;
  logic [ACC_W-1:0]  s1_c_reg;
  logic              s1_mode_reg;
  logic              s1_last_reg;

  // Stage 2 / architectural state
  logic              out_valid_reg;
  logic [ACC_W-1:0]  result_reg;
  logic              sat_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic              sticky_reg;

  // Combinational results computed from S1
  logic              advance;
  logic [ACC_W-1:0]  addend;
  logic [SUM_W-1:0]  prod_ext;
  logic [SUM_W-1:0]  sum_next;
  logic              ovf_next;
  logic [ACC_W-1:0]  result_next;

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic signed [PROD_W-1:0] prod_s;

  // The whole pipeline moves only when the output register can take a value.
  assign advance     = !out_valid_reg || bus.out_ready;
  assign bus.in_ready = advance && !bus.clear;

  assign a_s    = bus.a;
  assign b_s    = bus.b;
  assign prod_s = a_s * b_s;

  // Sign-extend the product and choose the addend, add at one extra bit so
  // overflow shows up as disagreement between the top two sum bits.
  always_comb begin
    prod_ext    = {{(SUM_W - PROD_W){s1_prod_reg[PROD_W-1]}}, s1_prod_reg};
    addend      = s1_mode_reg ? acc_reg : s1_c_reg;
    sum_next    = prod_ext + {addend[ACC_W-1], addend};
    ovf_next    = sum_next[ACC_W] ^ sum_next[ACC_W-1];
    result_next = sum_next[ACC_W-1:0];
    if (ovf_next) begin
      result_next = sum_next[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // S1 valid: loads whether an operand set is being taken this advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
    end else if (bus.clear) begin
      s1_valid_reg <= 1'b0;
    end else if (advance) begin
      s1_valid_reg <= bus.in_valid;
    end
  end

  // S1 data: meaningless while S1 is empty, so no reset is needed.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_prod_reg <= prod_s;
      s1_c_reg    <= bus.c;
      s1_mode_reg <= bus.mode;
      s1_last_reg <= bus.last;
    end
  end

  // S2, accumulator and sticky flag: the accumulator is written only when an
  // accumulate term lands in S2, so the next term in S1 always sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      sat_reg       <= 1'b0;
      acc_reg       <= '0;
      sticky_reg    <= 1'b0;
    end else if (bus.clear) begin
      out_valid_reg <= 1'b0;
      acc_reg       <= '0;
      sticky_reg    <= 1'b0;
    end else if (advance) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        result_reg <= result_next;
        sat_reg    <= ovf_next;
        sticky_reg <= sticky_reg | ovf_next;
        if (s1_mode_reg) begin
          acc_reg <= s1_last_reg ? '0 : result_next;
        end
      end
    end
  end

  assign bus.out_valid  = out_valid_reg;
  assign bus.result     = result_reg;
  assign bus.sat        = sat_reg;
  assign bus.sat_sticky = sticky_reg;
endmodule

// File: tb/tb_mac_pipe.sv
// Bench for mac_pipe: directed operand sets, an in-order expected-result queue
// computed with plain integer arithmetic, and a per-cycle output checker.
module tb_mac_pipe;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mac_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) ifc ();

  mac_pipe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [ACC_W-1:0] res;
    logic             sat;
    bit               has_lit;
    logic [ACC_W-1:0] lit;
    logic             lit_sat;
  } exp_t;

  exp_t   q[$];
  longint acc_m = 0;
  bit     sticky_m = 0;

  bit               cur_has_lit = 0;
  logic [ACC_W-1:0] cur_lit = '0;
  logic             cur_lit_sat = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic longint sat_fn(input longint s);
    longint mx;
    longint mn;
    mx = (longint'(1) <<< (ACC_W - 1)) - 1;
    mn = -(longint'(1) <<< (ACC_W - 1));
    if (s > mx) return mx;
    if (s < mn) return mn;
    return s;
  endfunction

  // Per-cycle checker and model update, evaluated mid-cycle while inputs and
  // outputs are stable; model changes describe what the coming edge does.
  always @(negedge clk) begin
    bit          exp_rdy;
    exp_t        e;
    longint      prod;
    longint      s;
    longint      sv;
    logic [63:0] svb;
    if (!rst_n) begin
      q.delete();
      acc_m    = 0;
      sticky_m = 0;
      chk("rst_out_valid", ifc.out_valid, 0);
      chk("rst_result", ifc.result, 0);
      chk("rst_sat", ifc.sat, 0);
      chk("rst_sticky", ifc.sat_sticky, 0);
    end else begin
      exp_rdy = !ifc.clear && (!ifc.out_valid || ifc.out_ready);
      chk("in_ready", ifc.in_ready, exp_rdy);
      if (ifc.out_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out got result=%0h exp=no_output t=%0t", ifc.result, $time);
        end else begin
          chk("result", ifc.result, q[0].res);
          chk("sat", ifc.sat, q[0].sat);
          chk("sticky", ifc.sat_sticky, sticky_m | q[0].sat);
          if (ifc.out_ready && q[0].has_lit) begin
            chk("lit_result", ifc.result, q[0].lit);
            chk("lit_sat", ifc.sat, q[0].lit_sat);
          end
        end
      end else begin
        chk("sticky_idle", ifc.sat_sticky, sticky_m);
      end

      if (ifc.clear) begin
        q.delete();
        acc_m    = 0;
        sticky_m = 0;
      end else begin
        if (ifc.out_valid && ifc.out_ready && q.size() > 0) begin
          sticky_m = sticky_m | q[0].sat;
          void'(q.pop_front());
        end
        if (ifc.in_valid && exp_rdy) begin
          prod = longint'($signed(ifc.a)) * longint'($signed(ifc.b));
          if (ifc.mode) begin
            s  = acc_m + prod;
            sv = sat_fn(s);
            acc_m = ifc.last ? 0 : sv;
          end else begin
            s  = prod + longint'($signed(ifc.c));
            sv = sat_fn(s);
          end
          svb       = sv;
          e.res     = svb[ACC_W-1:0];
          e.sat     = (sv != s);
          e.has_lit = cur_has_lit;
          e.lit     = cur_lit;
          e.lit_sat = cur_lit_sat;
          q.push_back(e);
        end
      end
    end
  end

  // Offer one operand set, holding it until the block takes it.
  task automatic send(input bit m, input bit l, input int av, input int bv,
                      input longint cv, input bit hl, input longint lit, input bit ls);
    int n;
    bit done;
    n    = 0;
    done = 0;
    ifc.in_valid = 1'b1;
    ifc.mode     = m;
    ifc.last     = l;
    ifc.a        = av[DATA_W-1:0];
    ifc.b        = bv[DATA_W-1:0];
    ifc.c        = cv[ACC_W-1:0];
    cur_has_lit  = hl;
    cur_lit      = lit[ACC_W-1:0];
    cur_lit_sat  = ls;
    while (!done) begin
      @(negedge clk);
      done = ifc.in_ready && !ifc.clear;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout got=in_ready_low exp=accept_within_50 t=%0t", $time);
        done = 1;
      end
    end
    ifc.in_valid = 1'b0;
    cur_has_lit  = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ifc.clear = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.mode = 1'b0;
    ifc.last = 1'b0;
    ifc.a = '0;
    ifc.b = '0;
    ifc.c = '0;
    ifc.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Multiply-add with latency check: S1 after one edge, result after two.
    send(0, 0, -5, 3, 10, 1, 'hFFFFFFFB, 0);
    @(negedge clk);
    chk("lat_one_edge", ifc.out_valid, 0);
    @(negedge clk);
    chk("lat_two_edges", ifc.out_valid, 1);
    chk("madd_neg", ifc.result, 'hFFFFFFFB);
    @(posedge clk);
    #1;
    idle(2);

    // Accumulation with an interleaved multiply-add, then restart after last.
    send(1, 0, 2, 3, 0, 1, 6, 0);
    send(0, 0, 1, 1, 5, 1, 6, 0);
    send(1, 0, 4, 5, 0, 1, 26, 0);
    send(1, 1, -1, 6, 0, 1, 20, 0);
    send(1, 1, 1, 1, 0, 1, 1, 0);
    idle(3);

    // Multiply-add saturation in both directions.
    send(0, 0, -32768, 32767, 'h80000000, 1, 'h80000000, 1);
    send(0, 0, -32768, -32768, 'h7FFFFFFF, 1, 'h7FFFFFFF, 1);
    idle(3);
    ifc.clear = 1'b1;
    idle(1);
    ifc.clear = 1'b0;
    @(negedge clk);
    chk("clear_sticky_a", ifc.sat_sticky, 0);
    @(posedge clk);
    #1;

    // Accumulate saturation, sticky set, then cleared.
    send(1, 0, -32768, -32768, 0, 1, 'h40000000, 0);
    send(1, 1, -32768, -32768, 0, 1, 'h7FFFFFFF, 1);
    idle(3);
    @(negedge clk);
    chk("sticky_set", ifc.sat_sticky, 1);
    @(posedge clk);
    #1;
    ifc.clear = 1'b1;
    idle(1);
    ifc.clear = 1'b0;
    @(negedge clk);
    chk("clear_sticky_b", ifc.sat_sticky, 0);
    @(posedge clk);
    #1;

    // Clear zeroes a partial accumulation, discards in-flight work and
    // refuses an operand offered in the same cycle.
    send(1, 0, 5, 5, 0, 1, 25, 0);
    idle(3);
    send(0, 0, 7, 7, 0, 0, 0, 0);
    ifc.clear = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.mode = 1'b0;
    ifc.a = 16'd100;
    ifc.b = 16'd100;
    @(negedge clk);
    chk("clear_in_ready", ifc.in_ready, 0);
    @(posedge clk);
    #1;
    ifc.clear = 1'b0;
    ifc.in_valid = 1'b0;
    idle(3);
    send(1, 1, 2, 2, 0, 1, 4, 0);
    idle(3);

    // Back-to-back transfers with a three-cycle downstream stall.
    fork
      begin
        send(0, 0, 1, 2, 3, 1, 5, 0);
        send(0, 0, -3, 4, 100, 1, 88, 0);
        send(0, 0, 10, 10, -1, 1, 99, 0);
        send(0, 0, -7, -7, 0, 1, 49, 0);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b0;
        @(negedge clk);
        chk("stall_in_ready", ifc.in_ready, 0);
        chk("stall_out_valid", ifc.out_valid, 1);
        chk("stall_hold_first", ifc.result, 5);
        repeat (3) @(posedge clk);
        #1;
        ifc.out_ready = 1'b1;
      end
    join
    idle(4);
    chk("stall_all_delivered", q.size(), 0);

    // Asynchronous reset with both stages full mid-accumulation.
    send(1, 0, 3, 4, 0, 0, 0, 0);
    send(1, 0, 2, 2, 0, 0, 0, 0);
    #1;
    chk("pre_rst_valid", ifc.out_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", ifc.out_valid, 0);
    chk("async_rst_result", ifc.result, 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(1, 1, 3, 3, 0, 1, 9, 0);
    idle(3);

    // Drain whatever is left and confirm nothing went missing.
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
